// File: rtl/hash_table_arbiter_pkg.sv
// Shared types for the hash table arbiter: table op encoding, response flag bit positions
// and the flush state machine encoding.
package hash_table_arbiter_pkg;

  typedef enum logic [1:0] {
    OpNone   = 2'b00,
    OpRead   = 2'b01,
    OpWrite  = 2'b10,
    OpDelete = 2'b11
  } ht_op_e;

  localparam int unsigned FlagKeyPresent   = 0;
  localparam int unsigned FlagNoElement    = 1;
  localparam int unsigned FlagNoWriteSpace = 2;
  localparam int unsigned FlagNoDelTarget  = 3;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StDone
  } arb_state_e;

endpackage

// File: rtl/tag_fifo.sv
// In-order FIFO of requester indices for commands issued to the table but not yet answered.
// Storage is not reset; only the pointers are, so reset empties it.
module tag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW:0]    wr_q;
  logic [PtrW:0]    rd_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[PtrW-1:0]] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_q[PtrW-1:0]];
  assign empty_o    = (wr_q == rd_q);

endmodule

// File: rtl/hash_table_arbiter.sv
// Round-robin arbiter in front of a hash table with in-order response routing and flush.
// Define HT_ARB_STATS_EN to add saturating per-requester grant and stall counters.
module hash_table_arbiter
  import hash_table_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned KEY_WIDTH  = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [2*NUM_REQ-1:0]            req_op_i,
  input  logic [KEY_WIDTH*NUM_REQ-1:0]    req_key_i,
  input  logic [DATA_WIDTH*NUM_REQ-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  output logic                            ht_valid_o,
  output logic [1:0]                      ht_op_o,
  output logic [KEY_WIDTH-1:0]            ht_key_o,
  output logic [DATA_WIDTH-1:0]           ht_data_o,
  output logic                            ht_ready_o,
  input  logic                            ht_valid_i,
  input  logic [DATA_WIDTH-1:0]           ht_read_data_i,
  input  logic [3:0]                      ht_flags_i,
  output logic [NUM_REQ-1:0]              resp_valid_o,
  output logic [DATA_WIDTH-1:0]           resp_data_o,
  output logic [3:0]                      resp_flags_o,
  input  logic                            flush_i,
  output logic                            flush_done_o,
`ifdef HT_ARB_STATS_EN
  output logic [16*NUM_REQ-1:0]           grant_cnt_o,
  output logic [15:0]                     stall_cnt_o,
`endif
  output logic                            err_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(TAG_DEPTH) + 1;

  arb_state_e              state_q, state_d;
  logic [IdxW-1:0]         ptr_q;
  logic [IdxW-1:0]         gnt_idx;
  logic                    gnt_any;
  logic [NUM_REQ-1:0]      req_vld;
  logic [1:0]              sel_op;
  logic [KEY_WIDTH-1:0]    sel_key;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [CntW-1:0]         outst_q;
  logic                    can_grant;
  logic                    push;
  logic                    pop;
  logic                    fifo_empty;
  logic [IdxW-1:0]         pop_tag;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_vld[i] = req_valid_i[i] && (req_op_i[2*i +: 2] != OpNone);
    end
  end

  // Scan starting at the priority pointer; first valid requester wins.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    sel_op   = OpNone;
    sel_key  = '0;
    sel_data = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      int unsigned k;
      k = (32'(ptr_q) + j) % NUM_REQ;
      if (!gnt_any && req_vld[k]) begin
        gnt_any  = 1'b1;
        gnt_idx  = IdxW'(k);
        sel_op   = req_op_i[2*k +: 2];
        sel_key  = req_key_i[KEY_WIDTH*k +: KEY_WIDTH];
        sel_data = req_data_i[DATA_WIDTH*k +: DATA_WIDTH];
      end
    end
  end

  // Reset gates ready combinationally so no grant is visible while reset is held.
  assign can_grant   = !reset && (state_q == StRun) && !flush_i &&
                       (outst_q < CntW'(TAG_DEPTH));
  assign push        = can_grant && gnt_any;
  assign pop         = ht_valid_i && !fifo_empty;
  assign req_ready_o = push ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign ht_ready_o  = 1'b1;

  tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .WIDTH (IdxW)
  ) u_tag_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (gnt_idx),
    .pop_i       (pop),
    .pop_data_o  (pop_tag),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (flush_i) state_d = StDrain;
      StDrain: if (outst_q == '0 && !ht_valid_o) state_d = StDone;
      StDone:  if (!flush_i) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StRun;
      ptr_q        <= '0;
      outst_q      <= '0;
      flush_done_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      state_q      <= state_d;
      outst_q      <= outst_q + CntW'(push) - CntW'(pop);
      flush_done_o <= (state_q == StDrain) && (state_d == StDone);
      if (push) ptr_q <= (gnt_idx == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      if (ht_valid_i && fifo_empty) err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ht_valid_o <= 1'b0;
      ht_op_o    <= OpNone;
      ht_key_o   <= '0;
      ht_data_o  <= '0;
    end else begin
      ht_valid_o <= push;
      ht_op_o    <= push ? sel_op : OpNone;
      ht_key_o   <= push ? sel_key : '0;
      ht_data_o  <= push ? sel_data : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid_o <= '0;
      resp_data_o  <= '0;
      resp_flags_o <= '0;
    end else begin
      resp_valid_o <= pop ? (NUM_REQ'(1) << pop_tag) : '0;
      if (pop) begin
        resp_data_o                    <= ht_read_data_i;
        resp_flags_o[FlagKeyPresent]   <= ht_flags_i[FlagKeyPresent];
        resp_flags_o[FlagNoElement]    <= ht_flags_i[FlagNoElement];
        resp_flags_o[FlagNoWriteSpace] <= ht_flags_i[FlagNoWriteSpace];
        resp_flags_o[FlagNoDelTarget]  <= ht_flags_i[FlagNoDelTarget];
      end
    end
  end

`ifdef HT_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (req_ready_o[i] && grant_cnt_o[16*i +: 16] != 16'hFFFF) begin
          grant_cnt_o[16*i +: 16] <= grant_cnt_o[16*i +: 16] + 16'd1;
        end
      end
      if (|req_vld && !push && stall_cnt_o != 16'hFFFF) stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hash_table_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized run against a queue-based model.
module tb_hash_table_arbiter;

  localparam int N  = 4;
  localparam int KW = 2;
  localparam int DW = 32;
  localparam int TD = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid;
  logic [2*N-1:0]  req_op;
  logic [KW*N-1:0] req_key;
  logic [DW*N-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            ht_valid_o;
  logic [1:0]      ht_op;
  logic [KW-1:0]   ht_key;
  logic [DW-1:0]   ht_data;
  logic            ht_ready;
  logic            ht_valid_in;
  logic [DW-1:0]   ht_rdata;
  logic [3:0]      ht_flags;
  logic [N-1:0]    resp_valid;
  logic [DW-1:0]   resp_data;
  logic [3:0]      resp_flags;
  logic            flush;
  logic            flush_done;
  logic            err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hash_table_arbiter #(
    .NUM_REQ    (N),
    .KEY_WIDTH  (KW),
    .DATA_WIDTH (DW),
    .TAG_DEPTH  (TD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid_i    (req_valid),
    .req_op_i       (req_op),
    .req_key_i      (req_key),
    .req_data_i     (req_data),
    .req_ready_o    (req_ready),
    .ht_valid_o     (ht_valid_o),
    .ht_op_o        (ht_op),
    .ht_key_o       (ht_key),
    .ht_data_o      (ht_data),
    .ht_ready_o     (ht_ready),
    .ht_valid_i     (ht_valid_in),
    .ht_read_data_i (ht_rdata),
    .ht_flags_i     (ht_flags),
    .resp_valid_o   (resp_valid),
    .resp_data_o    (resp_data),
    .resp_flags_o   (resp_flags),
    .flush_i        (flush),
    .flush_done_o   (flush_done),
    .err_o          (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid   = '0;
    req_op      = '0;
    req_key     = '0;
    req_data    = '0;
    ht_valid_in = 1'b0;
    ht_rdata    = '0;
    ht_flags    = '0;
    flush       = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [KW-1:0] key,
                         input logic [DW-1:0] data);
    req_op[2*i +: 2]     = op;
    req_key[KW*i +: KW]  = key;
    req_data[DW*i +: DW] = data;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < N; i++) set_req(i, 2'b01, KW'(i), DW'(i));
    req_valid = '1;
    tick();
    total++;
    if (req_ready !== 4'b0000 || ht_valid_o !== 1'b0 || ht_op !== 2'b00 ||
        resp_valid !== 4'b0000 || flush_done !== 1'b0 || err !== 1'b0 || ht_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_outputs: ready=%b htv=%b op=%b resp=%b fd=%b err=%b htr=%b (need 0,0,0,0,0,0,1)",
               req_ready, ht_valid_o, ht_op, resp_valid, flush_done, err, ht_ready);
    end
    reset = 1'b0;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL reset_first_grant: got %b need 0001", req_ready);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 2'b01, KW'(i), 32'h100 + i);
    for (int c = 0; c < 12; c++) begin
      req_valid   = (c < 8) ? 4'hF : 4'h0;
      ht_valid_in = (c >= 2 && c < 10);
      ht_rdata    = 32'hA000_0000 + c;
      #1;
      if (c < 8) begin
        exp = 4'(1 << (c % 4));
        total++;
        if (req_ready !== exp) begin
          bad++;
          $display("FAIL rr_grant c=%0d: got %b need %b", c, req_ready, exp);
        end
      end
      tick();
      total++;
      if (ht_valid_o !== (c < 8) || (c < 8 && ht_key !== KW'(c % 4))) begin
        bad++;
        $display("FAIL rr_cmd c=%0d: valid=%b key=%0d need valid=%b key=%0d",
                 c, ht_valid_o, ht_key, (c < 8), c % 4);
      end
      exp = (c >= 2 && c < 10) ? 4'(1 << ((c - 2) % 4)) : 4'b0;
      total++;
      if (resp_valid !== exp || (exp != 0 && resp_data !== 32'hA000_0000 + c)) begin
        bad++;
        $display("FAIL rr_resp c=%0d: got %b/%h need %b/%h", c, resp_valid, resp_data, exp,
                 32'hA000_0000 + c);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] exp;
    int grants;
    do_reset();
    set_req(1, 2'b10, 2'b11, 32'h55);
    grants = 0;
    for (int c = 0; c < 9; c++) begin
      req_valid   = 4'b0010;
      ht_valid_in = (c == 6);
      #1;
      exp = (c < 4 || c == 7) ? 4'b0010 : 4'b0000;
      if (c < 6 && req_ready[1] === 1'b1) grants++;
      total++;
      if (req_ready !== exp) begin
        bad++;
        $display("FAIL bp_ready c=%0d: got %b need %b", c, req_ready, exp);
      end
      tick();
      if (c == 6) begin
        total++;
        if (resp_valid !== 4'b0010) begin
          bad++;
          $display("FAIL bp_resp: got %b need 0010", resp_valid);
        end
      end
    end
    total++;
    if (grants !== 4) begin
      bad++;
      $display("FAIL bp_grant_count: got %0d need 4", grants);
    end
  endtask

  task automatic test_read_data();
    do_reset();
    set_req(2, 2'b01, 2'b01, 32'h0);
    req_valid = 4'b0100;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL rd_grant: got %b need 0100", req_ready);
    end
    tick();
    req_valid = '0;
    total++;
    if (ht_valid_o !== 1'b1 || ht_op !== 2'b01 || ht_key !== 2'b01) begin
      bad++;
      $display("FAIL rd_cmd: v=%b op=%b key=%b need 1/01/01", ht_valid_o, ht_op, ht_key);
    end
    ht_valid_in = 1'b1;
    ht_rdata    = 32'hDEADBEEF;
    ht_flags    = 4'b0000;
    tick();
    ht_valid_in = 1'b0;
    total++;
    if (resp_valid !== 4'b0100 || resp_data !== 32'hDEADBEEF || resp_flags !== 4'b0000) begin
      bad++;
      $display("FAIL rd_resp: got %b/%h/%b need 0100/deadbeef/0000", resp_valid, resp_data,
               resp_flags);
    end
    tick();
    total++;
    if (resp_valid !== 4'b0000 || ht_valid_o !== 1'b0 || ht_op !== 2'b00) begin
      bad++;
      $display("FAIL rd_idle: resp=%b htv=%b op=%b need 0", resp_valid, ht_valid_o, ht_op);
    end
  endtask

  task automatic test_flush();
    logic [N-1:0] exp;
    int pulses;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 2'b11, KW'(i), DW'(0));
    pulses = 0;
    for (int c = 0; c < 11; c++) begin
      req_valid   = (c < 3) ? 4'b0111 : 4'hF;
      flush       = (c == 3);
      ht_valid_in = (c >= 5 && c <= 7);
      ht_rdata    = 32'hF000 + c;
      #1;
      exp = (c < 3) ? 4'(1 << c) : ((c == 10) ? 4'b1000 : 4'b0000);
      total++;
      if (req_ready !== exp) begin
        bad++;
        $display("FAIL fl_ready c=%0d: got %b need %b", c, req_ready, exp);
      end
      tick();
      if (flush_done === 1'b1) pulses++;
      total++;
      if (flush_done !== (c == 8)) begin
        bad++;
        $display("FAIL fl_done c=%0d: got %b need %b", c, flush_done, (c == 8));
      end
      exp = (c >= 5 && c <= 7) ? 4'(1 << (c - 5)) : 4'b0000;
      total++;
      if (resp_valid !== exp) begin
        bad++;
        $display("FAIL fl_resp c=%0d: got %b need %b", c, resp_valid, exp);
      end
    end
    flush = 1'b0;
    total++;
    if (pulses !== 1) begin
      bad++;
      $display("FAIL fl_pulse_count: got %0d need 1", pulses);
    end
  endtask

  task automatic test_err();
    do_reset();
    ht_valid_in = 1'b1;
    ht_rdata    = 32'h1234;
    tick();
    ht_valid_in = 1'b0;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (err !== 1'b1 || resp_valid !== 4'b0000) begin
        bad++;
        $display("FAIL err_sticky c=%0d: err=%b resp=%b need 1/0000", c, err, resp_valid);
      end
      tick();
    end
    reset = 1'b1;
    #1;
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear: got %b need 0", err);
    end
    reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 2'b10, KW'(i), 32'hC0 + i);
    req_valid = '1;
    repeat (3) tick();
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (req_ready !== '0 || ht_valid_o !== 1'b0 || ht_op !== 2'b00 || ht_key !== '0 ||
        ht_data !== '0 || ht_ready !== 1'b1 || resp_valid !== '0 || resp_data !== '0 ||
        resp_flags !== '0 || flush_done !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_outputs: rdy=%b htv=%b op=%b key=%b dat=%h htr=%b resp=%b err=%b",
               req_ready, ht_valid_o, ht_op, ht_key, ht_data, ht_ready, resp_valid, err);
    end
    tick();
    reset       = 1'b0;
    req_valid   = '0;
    ht_valid_in = 1'b1;
    tick();
    ht_valid_in = 1'b0;
    total++;
    if (err !== 1'b1 || resp_valid !== '0) begin
      bad++;
      $display("FAIL mid_reset_stale: err=%b resp=%b need 1/0000", err, resp_valid);
    end
    req_valid = '1;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL mid_reset_first_grant: got %b need 0001", req_ready);
    end
  endtask

  task automatic test_random();
    int            q[$];
    int            ptr;
    int            g;
    int            idx;
    int            tag;
    logic          hv;
    logic [N-1:0]  exp_ready;
    logic [N-1:0]  exp_resp;
    logic [1:0]    exp_op;
    logic [KW-1:0] exp_key;
    logic [DW-1:0] exp_data;
    logic [DW-1:0] exp_rdata;
    logic [3:0]    exp_flags;
    do_reset();
    ptr = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        set_req(i, 2'($urandom_range(0, 3)), KW'($urandom), DW'($urandom));
      end
      req_valid   = N'($urandom_range(0, 15));
      hv          = (q.size() > 0) && ($urandom_range(0, 3) != 0);
      ht_valid_in = hv;
      ht_rdata    = DW'($urandom);
      ht_flags    = 4'($urandom_range(0, 15));

      g = -1;
      if (q.size() < TD) begin
        for (int k = 0; k < N; k++) begin
          idx = (ptr + k) % N;
          if (g < 0 && req_valid[idx] && req_op[2*idx +: 2] != 2'b00) g = idx;
        end
      end
      exp_ready = (g >= 0) ? N'(1 << g) : '0;
      if (g >= 0) begin
        exp_op   = req_op[2*g +: 2];
        exp_key  = req_key[KW*g +: KW];
        exp_data = req_data[DW*g +: DW];
      end
      exp_resp  = '0;
      exp_rdata = ht_rdata;
      exp_flags = ht_flags;
      if (hv) begin
        tag      = q.pop_front();
        exp_resp = N'(1 << tag);
      end
      if (g >= 0) begin
        q.push_back(g);
        ptr = (g + 1) % N;
      end

      #1;
      total++;
      if (req_ready !== exp_ready) begin
        bad++;
        $display("FAIL rnd_ready c=%0d: got %b need %b", c, req_ready, exp_ready);
      end
      tick();
      total++;
      if (ht_valid_o !== (g >= 0) ||
          (g >= 0 && (ht_op !== exp_op || ht_key !== exp_key || ht_data !== exp_data)) ||
          (g < 0 && ht_op !== 2'b00)) begin
        bad++;
        $display("FAIL rnd_cmd c=%0d: v=%b op=%b key=%b data=%h need v=%b op=%b key=%b data=%h",
                 c, ht_valid_o, ht_op, ht_key, ht_data, (g >= 0), exp_op, exp_key, exp_data);
      end
      total++;
      if (resp_valid !== exp_resp ||
          (hv && (resp_data !== exp_rdata || resp_flags !== exp_flags))) begin
        bad++;
        $display("FAIL rnd_resp c=%0d: got %b/%h/%b need %b/%h/%b", c, resp_valid, resp_data,
                 resp_flags, exp_resp, exp_rdata, exp_flags);
      end
    end
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL rnd_err: got %b need 0", err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_round_robin();
    test_backpressure();
    test_read_data();
    test_flush();
    test_err();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
